reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Shares the single write port of the I2C register file between two requesters. Requester 0 is the I2C slave write path; requester 1 is the IO datapath write-back (status/sampled input). The block grants bursty write tenures with round-robin fairness and a burst cap. It also filters out-of-range addresses. It drives one registered write port (we/waddr/wdata) into the register memory.

Parameters:
NUM_REGS, 16, number of valid register indices; an address >= NUM_REGS is out of range.
ADDR_W, 5, address width of both requesters and waddr.
DATA_W, 8, register data width.
MAX_BURST, 4, max accepted beats per tenure before forced release (>=1).
PROT_LIMIT, 4, indices 0..PROT_LIMIT-1 are protected from requester 1 (used only with ARB_WRITE_PROTECT_EN).

Ports:
clock  input  1  system clock (divided I2C-domain clock)
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 (I2C) wants/continues tenure
addr0  input  ADDR_W  requester 0 beat address
data0  input  DATA_W  requester 0 beat data
last0  input  1  requester 0 final beat of burst
gnt0  output  1  requester 0 owns the port
req1, addr1, data1, last1  input  1/ADDR_W/DATA_W/1  requester 1, same meaning
gnt1  output  1  requester 1 owns the port
we  output  1  register write strobe, one cycle per committed beat
waddr  output  ADDR_W  write index
wdata  output  DATA_W  write data
owner  output  1  requester whose beat is on we (0/1)
err  output  1  one-cycle pulse: beat accepted but dropped (out of range or protected)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On reset: state=IDLE, gnt0=gnt1=0, we=0, waddr=0, wdata=0, owner=0, err=0, burst count=0, round-robin pointer favours requester 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE: only req0 -> OWN0. Only req1 -> OWN1. Both -> the requester favoured by the rr pointer. Neither -> stay. All outputs are registered, so gntX rises the cycle after reqX is seen in IDLE.
- OWNx: gntx=1, the other grant=0. A beat is accepted in any cycle with reqx&gntx.
- Accepted beat in cycle N -> we/waddr/wdata/owner valid in cycle N+1, for exactly one cycle. Latency is req→gnt 1 cycle and beat→we 1 cycle.
- Accepted beat with addr >= NUM_REGS: no we; err=1 in cycle N+1.
- Burst count increments per accepted beat and clears on entry to IDLE.
- Tenure ends (next state IDLE, gnt drops next cycle) on any of:
  - an accepted beat with lastx=1;
  - an accepted beat making the count equal MAX_BURST;
  - reqx=0 while in OWNx (abort; no write that cycle).
- At tenure end the rr pointer favours the other requester.
- At least one IDLE cycle always separates tenures, even if the other requester is pending. No back-to-back grant across owners.
- Non-owner requests are held pending; they are never dropped or written.
- Async reset mid-tenure: grant and any pending we are cleared immediately. The partially accepted burst is not replayed.
- waddr/wdata hold their last value when we=0.

Optional Feature:
Macro ARB_WRITE_PROTECT_EN.
- Defined: a requester-1 beat with addr < PROT_LIMIT is accepted (counts toward the burst) but suppressed. No we; err=1 next cycle. Requester 0 is unaffected.
- Undefined: all in-range beats from either requester are written. PROT_LIMIT is ignored.

Test Plan:
1. Reset, req0=1, addr0=3, data0=8'hA5, last0=1 in one cycle. Expected: gnt0=1 next cycle; beat accepted; following cycle we=1, waddr=3, wdata=A5, owner=0; then IDLE, gnt0=0.
2. req0 and req1 both high from reset. Expected: requester 0 granted first. After its last beat there is one IDLE cycle, then gnt1=1 (rr alternation); a subsequent simultaneous request grants requester 0 again.
3. Requester 1 holds req1 with last1=0 for 6 beats (addr 4..9) and MAX_BURST=4. Expected: 4 we pulses (addr 4..7), then gnt1 drops. If req0 is pending it is granted next; requester 1 resumes later at addr 8.
4. Beat with addr0=16 (NUM_REGS=16), data 8'h3C. Expected: no we; err=1 for one cycle; tenure continues or ends per last0.
5. Assert reset while gnt1=1 with a beat accepted the previous cycle. Expected: we, gnt1 and err go 0 immediately with no clock edge. After release, IDLE, and the rr pointer favours requester 0.
6. With ARB_WRITE_PROTECT_EN, requester 1 writes addr 2 data 8'hFF, then addr 5 data 8'h11. Expected: first beat gives err=1, no we; second gives we=1, waddr=5, wdata=11. Without the macro, both are written.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Two-requester write-port bundle: burst requests in, grants and the registered write port out.
interface reg_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              last0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              last1;
  logic              gnt1;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              owner;
  logic              err;

  modport master (
    output req0, addr0, data0, last0, req1, addr1, data1, last1,
    input  gnt0, gnt1, we, waddr, wdata, owner, err
  );

  modport slave (
    input  req0, addr0, data0, last0, req1, addr1, data1, last1,
    output gnt0, gnt1, we, waddr, wdata, owner, err
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin burst arbiter for the register-file write port; 1-cycle req->gnt and beat->we latency.
// ARB_WRITE_PROTECT_EN: when defined, requester-1 beats below PROT_LIMIT are accepted but suppressed.
module reg_write_arbiter #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 4,
  parameter int PROT_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]  NREG    = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0]  PLIM    = (ADDR_W + 1)'(PROT_LIMIT);
`ifdef ARB_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             rr;     // 0: requester 0 wins a tie in IDLE
  logic [CNT_W-1:0] cnt;

  logic             oor0;
  logic             drop1;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_done;

  always_comb begin
    oor0       = {1'b0, bus.addr0} >= NREG;
    drop1      = ({1'b0, bus.addr1} >= NREG) || (PROT_EN && ({1'b0, bus.addr1} < PLIM));
    cnt_inc    = cnt + CNT_W'(1);
    burst_done = (cnt_inc == MAX_CNT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cnt       <= '0;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.owner <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.we  <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req0 && (!bus.req1 || !rr)) begin
            state    <= OWN0;
            bus.gnt0 <= 1'b1;
          end else if (bus.req1) begin
            state    <= OWN1;
            bus.gnt1 <= 1'b1;
          end
        end
        OWN0: begin
          if (bus.req0) begin
            cnt <= cnt_inc;
            if (oor0) begin
              bus.err <= 1'b1;
            end else begin
              bus.we    <= 1'b1;
              bus.waddr <= bus.addr0;
              bus.wdata <= bus.data0;
              bus.owner <= 1'b0;
            end
          end
          // Tenure ends on last beat, burst cap, or abort; always via IDLE.
          if (!bus.req0 || bus.last0 || burst_done) begin
            state    <= IDLE;
            bus.gnt0 <= 1'b0;
            rr       <= 1'b1;
            cnt      <= '0;
          end
        end
        OWN1: begin
          if (bus.req1) begin
            cnt <= cnt_inc;
            if (drop1) begin
              bus.err <= 1'b1;
            end else begin
              bus.we    <= 1'b1;
              bus.waddr <= bus.addr1;
              bus.wdata <= bus.data1;
              bus.owner <= 1'b1;
            end
          end
          if (!bus.req1 || bus.last1 || burst_done) begin
            state    <= IDLE;
            bus.gnt1 <= 1'b0;
            rr       <= 1'b0;
            cnt      <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.gnt0 <= 1'b0;
          bus.gnt1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; expectations are hand-computed per cycle.
module tb_reg_write_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  reg_write_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  reg_write_arbiter #(
    .NUM_REGS(16), .ADDR_W(5), .DATA_W(8), .MAX_BURST(4), .PROT_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0; bus.last0 = 1'b0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0; bus.last1 = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    tick();
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b0;

    // 1: single-beat write from requester 0
    bus.req0 = 1; bus.addr0 = 3; bus.data0 = 8'hA5; bus.last0 = 1;
    tick();
    check("t1_gnt0", bus.gnt0, 1);
    check("t1_we_early", bus.we, 0);
    tick();
    check("t1_we", bus.we, 1);
    check("t1_waddr", bus.waddr, 3);
    check("t1_wdata", bus.wdata, 8'hA5);
    check("t1_owner", bus.owner, 0);
    check("t1_gnt0_drop", bus.gnt0, 0);
    bus.req0 = 0;
    tick();
    check("t1_we_pulse", bus.we, 0);
    check("t1_gnt0_idle", bus.gnt0, 0);

    // 2: simultaneous requests alternate, with an idle gap between owners
    apply_reset();
    bus.req0 = 1; bus.addr0 = 1; bus.data0 = 8'h11; bus.last0 = 1;
    bus.req1 = 1; bus.addr1 = 2; bus.data1 = 8'h22; bus.last1 = 1;
    tick();
    check("t2_gnt0_first", bus.gnt0, 1);
    check("t2_gnt1_wait", bus.gnt1, 0);
    tick();
    check("t2_we0", bus.we, 1);
    check("t2_waddr0", bus.waddr, 1);
    check("t2_gap_gnt1", bus.gnt1, 0);
    bus.req0 = 0;
    tick();
    check("t2_gnt1", bus.gnt1, 1);
    check("t2_gap_we", bus.we, 0);
    tick();
    check("t2_we1", bus.we, 1);
    check("t2_waddr1", bus.waddr, 2);
    check("t2_owner1", bus.owner, 1);
    check("t2_gnt1_drop", bus.gnt1, 0);
    bus.req0 = 1;
    tick();
    check("t2_rr_gnt0", bus.gnt0, 1);
    check("t2_rr_gnt1", bus.gnt1, 0);
    tick();
    check("t2_we0b", bus.we, 1);
    bus.req0 = 0; bus.req1 = 0;
    tick();

    // 3: burst cap of 4 on requester 1 with requester 0 pending
    apply_reset();
    bus.req1 = 1; bus.addr1 = 4; bus.data1 = 8'h40; bus.last1 = 0;
    tick();
    check("t3_gnt1", bus.gnt1, 1);
    bus.req0 = 1; bus.addr0 = 10; bus.data0 = 8'hAA; bus.last0 = 1;
    for (int i = 0; i < 4; i++) begin
      bus.addr1 = 5'(4 + i); bus.data1 = 8'(8'h40 + i);
      tick();
      check("t3_we", bus.we, 1);
      check("t3_waddr", bus.waddr, 4 + i);
      check("t3_wdata", bus.wdata, 8'h40 + i);
      check("t3_gnt1", bus.gnt1, (i < 3) ? 1 : 0);
      check("t3_gnt0_pending", bus.gnt0, 0);
    end
    bus.addr1 = 8; bus.data1 = 8'h48;
    tick();
    check("t3_gnt0", bus.gnt0, 1);
    check("t3_gap_we", bus.we, 0);
    tick();
    check("t3_we0", bus.we, 1);
    check("t3_waddr0", bus.waddr, 10);
    check("t3_owner0", bus.owner, 0);
    bus.req0 = 0;
    tick();
    check("t3_gnt1_resume", bus.gnt1, 1);
    tick();
    check("t3_waddr8", bus.waddr, 8);
    check("t3_we8", bus.we, 1);
    bus.addr1 = 9; bus.data1 = 8'h49; bus.last1 = 1;
    tick();
    check("t3_waddr9", bus.waddr, 9);
    check("t3_gnt1_end", bus.gnt1, 0);
    bus.req1 = 0; bus.last1 = 0;
    tick();
    check("t3_idle_we", bus.we, 0);

    // 4: out-of-range beat mid-burst
    apply_reset();
    bus.req0 = 1; bus.addr0 = 16; bus.data0 = 8'h3C; bus.last0 = 0;
    tick();
    check("t4_gnt0", bus.gnt0, 1);
    tick();
    check("t4_oor_we", bus.we, 0);
    check("t4_oor_err", bus.err, 1);
    check("t4_waddr_hold", bus.waddr, 0);
    check("t4_gnt0_cont", bus.gnt0, 1);
    bus.addr0 = 5; bus.data0 = 8'h55; bus.last0 = 1;
    tick();
    check("t4_we", bus.we, 1);
    check("t4_waddr", bus.waddr, 5);
    check("t4_err_pulse", bus.err, 0);
    check("t4_gnt0_end", bus.gnt0, 0);
    bus.req0 = 0; bus.last0 = 0;
    tick();

    // 5: async reset mid-tenure; rr currently favours requester 1
    bus.req1 = 1; bus.addr1 = 6; bus.data1 = 8'h66; bus.last1 = 0;
    tick();
    check("t5_gnt1", bus.gnt1, 1);
    tick();
    check("t5_we", bus.we, 1);
    reset = 1'b1;
    #1;
    check("t5_async_we", bus.we, 0);
    check("t5_async_gnt1", bus.gnt1, 0);
    check("t5_async_err", bus.err, 0);
    bus.req0 = 1; bus.addr0 = 7; bus.data0 = 8'h77; bus.last0 = 1;
    tick();
    reset = 1'b0;
    tick();
    check("t5_rr_gnt0", bus.gnt0, 1);
    check("t5_rr_gnt1", bus.gnt1, 0);
    tick();
    check("t5_we0", bus.we, 1);
    check("t5_waddr0", bus.waddr, 7);
    bus.req0 = 0; bus.req1 = 0;
    tick();

    // 6: protected low indices for requester 1
    apply_reset();
    bus.req1 = 1; bus.addr1 = 2; bus.data1 = 8'hFF; bus.last1 = 0;
    tick();
    check("t6_gnt1", bus.gnt1, 1);
    bus.addr1 = 2;
    tick();
`ifdef ARB_WRITE_PROTECT_EN
    check("t6_prot_we", bus.we, 0);
    check("t6_prot_err", bus.err, 1);
`else
    check("t6_open_we", bus.we, 1);
    check("t6_open_waddr", bus.waddr, 2);
    check("t6_open_wdata", bus.wdata, 8'hFF);
    check("t6_open_err", bus.err, 0);
`endif
    bus.addr1 = 5; bus.data1 = 8'h11; bus.last1 = 1;
    tick();
    check("t6_we5", bus.we, 1);
    check("t6_waddr5", bus.waddr, 5);
    check("t6_wdata11", bus.wdata, 8'h11);
    check("t6_err5", bus.err, 0);
    bus.req1 = 0; bus.last1 = 0;
    bus.req0 = 1; bus.addr0 = 2; bus.data0 = 8'h77; bus.last0 = 1;
    tick();
    check("t6_gnt0", bus.gnt0, 1);
    tick();
    check("t6_r0_we", bus.we, 1);
    check("t6_r0_waddr", bus.waddr, 2);
    check("t6_r0_err", bus.err, 0);
    bus.req0 = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
